// File: rtl/serial_addsub_unit_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
// The producer side drives operands and out_ready; the unit drives the rest.
interface serial_addsub_unit_if #(
   parameter int WIDTH = 8
);
   // valid/ready: a transfer happens on a rising edge where valid and ready are both high;
   // valid never depends on ready, and the sender keeps its payload stable until that edge.
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             overflow;
   logic             busy;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, sum, carry, overflow, busy
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, sum, carry, overflow, busy
   );
endinterface

// File: rtl/serial_addsub_unit.sv
// Digit-serial add/subtract: DIGIT bits per clock, with the ripple carry kept in a register.
// Subtraction is done as A + ~B + 1, with the +1 injected as the initial carry.
module serial_addsub_unit #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_addsub_unit_if.slave  bus,
   output logic [1:0]           dbg_state
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = $clog2(N + 1);

   generate
      if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("serial_addsub_unit: WIDTH must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] res_reg;
   logic             carry_reg;
   logic             carry_out;
   logic             ovf_out;
   logic             a_msb;
   logic             b_msb;
   logic [CW-1:0]    cnt;
   logic [DIGIT:0]   dsum;

   always_comb begin
      dsum = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_reg};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         res_reg   <= '0;
         carry_reg <= 1'b0;
         carry_out <= 1'b0;
         ovf_out   <= 1'b0;
         a_msb     <= 1'b0;
         b_msb     <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_reg     <= bus.a;
                  b_reg     <= bus.sub ? ~bus.b : bus.b;
                  carry_reg <= bus.sub;
                  a_msb     <= bus.a[WIDTH-1];
                  b_msb     <= bus.sub ^ bus.b[WIDTH-1];
                  cnt       <= '0;
                  state     <= RUN;
               end
            end
            RUN: begin
               // New digit enters at the top; after N digits the result is aligned.
               res_reg   <= WIDTH'({dsum[DIGIT-1:0], res_reg} >> DIGIT);
               carry_reg <= dsum[DIGIT];
               a_reg     <= a_reg >> DIGIT;
               b_reg     <= b_reg >> DIGIT;
               cnt       <= cnt + 1'b1;
               if (cnt == CW'(N - 1)) begin
                  carry_out <= dsum[DIGIT];
                  ovf_out   <= (a_msb == b_msb) && (dsum[DIGIT-1] != a_msb);
                  state     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state != IDLE);
   assign bus.sum       = res_reg;
   assign bus.carry     = carry_out;
   assign bus.overflow  = ovf_out;
   assign dbg_state     = state;
endmodule

// File: tb/tb_serial_addsub_unit.sv
// Bench for serial_addsub_unit: directed scenarios on an 8/2 instance plus a
// randomized sweep over several WIDTH/DIGIT instances against an arithmetic model.
module tb_serial_addsub_unit;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   bit   sweep_start;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   serial_addsub_unit_if #(.WIDTH(8)) mif();
   logic [1:0] mdbg;

   serial_addsub_unit #(.WIDTH(8), .DIGIT(2)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (mif.slave),
      .dbg_state (mdbg)
   );

   // Reference: plain modular and signed integer arithmetic.
   function automatic void ref_op(input int w, input longint ua, input longint ub, input bit s,
                                  output longint rs, output bit rc, output bit ro);
      longint m, full, sa, sb, r;
      m    = longint'(1) << w;
      full = s ? (ua + (m - ub)) : (ua + ub);
      rs   = full % m;
      rc   = (full >= m);
      sa   = (ua >= m / 2) ? ua - m : ua;
      sb   = (ub >= m / 2) ? ub - m : ub;
      r    = s ? (sa - sb) : (sa + sb);
      ro   = (r < -(m / 2)) || (r > (m / 2 - 1));
   endfunction

   // Driver: presents one operation, returns the edges from accept to out_valid.
   task automatic issue(input logic [7:0] ta, input logic [7:0] tbv, input logic ts,
                        output int lat, output bit busy_ok);
      mif.a = ta; mif.b = tbv; mif.sub = ts; mif.in_valid = 1'b1;
      @(posedge clk); #1;
      mif.in_valid = 1'b0;
      mif.a = 8'($urandom); mif.b = 8'($urandom); mif.sub = 1'($urandom_range(0, 1));
      lat = 0; busy_ok = 1'b1;
      while (!mif.out_valid && lat < 64) begin
         if (!mif.busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      if (!mif.busy) busy_ok = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mif.in_valid = 1'b0; mif.a = '0; mif.b = '0; mif.sub = 1'b0; mif.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      n_checks++;
      if ({mif.in_ready, mif.out_valid, mif.busy, mif.carry, mif.overflow} !== 5'b10000 || mif.sum !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_state: got rdy=%b vld=%b busy=%b c=%b v=%b sum=%h, expected rdy=1 others 0",
                  mif.in_ready, mif.out_valid, mif.busy, mif.carry, mif.overflow, mif.sum);
      end
   endtask

   task automatic run_table(input string name, input logic [7:0] ta[3], input logic [7:0] tbv[3], input logic ts);
      int lat; bit bok; longint es; bit ec, eo;
      mif.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ref_op(8, longint'(ta[i]), longint'(tbv[i]), ts, es, ec, eo);
         issue(ta[i], tbv[i], ts, lat, bok);
         n_checks++;
         if (lat !== 4 || !bok) begin
            n_fail++;
            $display("FAIL %s_latency[%0d]: got %0d busy_ok=%b, expected 4 busy_ok=1", name, i, lat, bok);
         end
         n_checks++;
         if (mif.sum !== 8'(es) || mif.carry !== ec || mif.overflow !== eo) begin
            n_fail++;
            $display("FAIL %s_result[%0d]: got sum=%h c=%b v=%b, expected sum=%h c=%b v=%b",
                     name, i, mif.sum, mif.carry, mif.overflow, 8'(es), ec, eo);
         end
         @(posedge clk); #1;
         n_checks++;
         if (mif.out_valid !== 1'b0 || mif.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_return_idle[%0d]: got vld=%b rdy=%b, expected vld=0 rdy=1",
                     name, i, mif.out_valid, mif.in_ready);
         end
      end
   endtask

   task automatic test_add();
      logic [7:0] ta[3];
      logic [7:0] tbv[3];
      ta  = '{8'h5A, 8'hFF, 8'h7F};
      tbv = '{8'h3C, 8'h01, 8'h01};
      run_table("add", ta, tbv, 1'b0);
   endtask

   task automatic test_sub();
      logic [7:0] ta[3];
      logic [7:0] tbv[3];
      ta  = '{8'h10, 8'h80, 8'h33};
      tbv = '{8'h20, 8'h01, 8'h33};
      run_table("sub", ta, tbv, 1'b1);
   endtask

   task automatic test_backpressure();
      int lat; bit bok; longint es; bit ec, eo;
      mif.out_ready = 1'b0;
      ref_op(8, 64'hA5, 64'h6C, 1'b0, es, ec, eo);
      issue(8'hA5, 8'h6C, 1'b0, lat, bok);
      n_checks++;
      if (lat !== 4) begin
         n_fail++;
         $display("FAIL bp_latency: got %0d, expected 4", lat);
      end
      for (int i = 0; i < 6; i++) begin
         mif.in_valid = 1'($urandom_range(0, 1));
         mif.a = 8'($urandom); mif.b = 8'($urandom); mif.sub = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         n_checks++;
         if (mif.out_valid !== 1'b1 || mif.in_ready !== 1'b0 || mif.sum !== 8'(es) ||
             mif.carry !== ec || mif.overflow !== eo) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b sum=%h c=%b v=%b, expected vld=1 rdy=0 sum=%h c=%b v=%b",
                     i, mif.out_valid, mif.in_ready, mif.sum, mif.carry, mif.overflow, 8'(es), ec, eo);
         end
      end
      mif.in_valid = 1'b0;
      mif.out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (mif.out_valid !== 1'b0 || mif.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release: got vld=%b rdy=%b, expected vld=0 rdy=1", mif.out_valid, mif.in_ready);
      end
      ref_op(8, 64'h12, 64'h34, 1'b1, es, ec, eo);
      issue(8'h12, 8'h34, 1'b1, lat, bok);
      n_checks++;
      if (lat !== 4 || mif.sum !== 8'(es) || mif.carry !== ec || mif.overflow !== eo) begin
         n_fail++;
         $display("FAIL bp_second_op: got lat=%0d sum=%h c=%b v=%b, expected lat=4 sum=%h c=%b v=%b",
                  lat, mif.sum, mif.carry, mif.overflow, 8'(es), ec, eo);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_run();
      int lat; bit bok;
      mif.out_ready = 1'b1;
      mif.a = 8'hF7; mif.b = 8'hE9; mif.sub = 1'b0; mif.in_valid = 1'b1;
      @(posedge clk); #1;
      mif.in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++;
      if ({mif.in_ready, mif.out_valid, mif.busy, mif.carry, mif.overflow} !== 5'b10000 || mif.sum !== 8'h00) begin
         n_fail++;
         $display("FAIL abort_state: got rdy=%b vld=%b busy=%b c=%b v=%b sum=%h, expected rdy=1 others 0",
                  mif.in_ready, mif.out_valid, mif.busy, mif.carry, mif.overflow, mif.sum);
      end
      issue(8'h01, 8'h02, 1'b0, lat, bok);
      n_checks++;
      if (lat !== 4 || mif.sum !== 8'h03 || mif.carry !== 1'b0 || mif.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_next_op: got lat=%0d sum=%h c=%b v=%b, expected lat=4 sum=03 c=0 v=0",
                  lat, mif.sum, mif.carry, mif.overflow);
      end
      @(posedge clk); #1;
   endtask

   for (genvar g = 0; g < 5; g++) begin : g_sweep
      localparam int W = (g == 4) ? 16 : 8;
      localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 8 : 4;
      localparam int N = W / D;
      serial_addsub_unit_if #(.WIDTH(W)) sif();
      logic [1:0] sdbg;
      bit         done;

      serial_addsub_unit #(.WIDTH(W), .DIGIT(D)) u_sweep (
         .clk       (clk),
         .rst       (rst),
         .bus       (sif.slave),
         .dbg_state (sdbg)
      );

      initial begin : drive
         logic [W-1:0] ra, rb, es;
         logic         rs, rr;
         longint       lres;
         bit           ec, eo, hs;
         int           lat, guard;
         done = 1'b0;
         sif.in_valid = 1'b0; sif.a = '0; sif.b = '0; sif.sub = 1'b0; sif.out_ready = 1'b0;
         wait (sweep_start);
         for (int n = 0; n < 200; n++) begin
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom_range(0, 1));
            ref_op(W, longint'(ra), longint'(rb), rs, lres, ec, eo);
            es = W'(lres);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            sif.a = ra; sif.b = rb; sif.sub = rs; sif.in_valid = 1'b1;
            @(posedge clk); #1;
            sif.in_valid = 1'b0;
            sif.a = W'($urandom); sif.b = W'($urandom); sif.sub = ~rs;
            lat = 0;
            while (!sif.out_valid && lat < 100) begin
               sif.out_ready = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
               lat++;
            end
            n_checks++;
            if (lat !== N || sif.sum !== es || sif.carry !== ec || sif.overflow !== eo) begin
               n_fail++;
               $display("FAIL sweep_w%0d_d%0d[%0d]: %h %s %h got lat=%0d sum=%h c=%b v=%b, expected lat=%0d sum=%h c=%b v=%b",
                        W, D, n, ra, rs ? "-" : "+", rb, lat, sif.sum, sif.carry, sif.overflow, N, es, ec, eo);
            end
            hs = 1'b0; guard = 0;
            while (!hs && guard < 100) begin
               rr = 1'($urandom_range(0, 1));
               sif.out_ready = rr;
               @(posedge clk); #1;
               guard++;
               if (rr) hs = 1'b1;
               else begin
                  n_checks++;
                  if (sif.out_valid !== 1'b1 || sif.sum !== es) begin
                     n_fail++;
                     $display("FAIL sweep_w%0d_d%0d_hold[%0d]: got vld=%b sum=%h, expected vld=1 sum=%h",
                              W, D, n, sif.out_valid, sif.sum, es);
                  end
               end
            end
            n_checks++;
            if (sif.out_valid !== 1'b0 || sif.in_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL sweep_w%0d_d%0d_release[%0d]: got vld=%b rdy=%b, expected vld=0 rdy=1",
                        W, D, n, sif.out_valid, sif.in_ready);
            end
         end
         done = 1'b1;
      end
   end

   task automatic test_sweep();
      int guard;
      sweep_start = 1'b1;
      guard = 0;
      while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done && g_sweep[4].done)
             && guard < 40000) begin
         @(posedge clk);
         guard++;
      end
      n_checks++;
      if (guard >= 40000) begin
         n_fail++;
         $display("FAIL sweep_timeout: got %0d cycles without completion, expected completion", guard);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      sweep_start = 1'b0;
      rst = 1'b1;
      test_reset();
      test_add();
      test_sub();
      test_backpressure();
      test_reset_mid_run();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
